// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: register widths, special register numbers
// and the stack-pointer reset value.
package mips_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;

  localparam logic [31:0] SP_RESET_DEF = 32'd227;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_SP   = 5'd29;
  localparam logic [4:0] REG_R30  = 5'd30;
  localparam logic [4:0] REG_RA   = 5'd31;

endpackage

// File: rtl/reg_bank_if.sv
// Register-bank access bundle: one write port and two read ports.
interface reg_bank_if
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
);

  logic              RegWrite;
  logic [ADDR_W-1:0] WriteReg;
  logic [DATA_W-1:0] WriteData;
  logic [ADDR_W-1:0] ReadReg1;
  logic [ADDR_W-1:0] ReadReg2;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;

  modport master (
    output RegWrite, WriteReg, WriteData, ReadReg1, ReadReg2,
    input  ReadData1, ReadData2
  );

  modport slave (
    input  RegWrite, WriteReg, WriteData, ReadReg1, ReadReg2,
    output ReadData1, ReadData2
  );

endinterface

// File: rtl/reg_read_port.sv
// One registered read port: $0 forces zero, a same-edge write to the
// addressed register is forwarded, otherwise the array word is captured.
module reg_read_port #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] array_data,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] rd_next;

  // Select zero, bypassed write data, or stored word for the next capture.
  always_comb begin
    rd_next = array_data;
    if (rd_addr == '0) begin
      rd_next = '0;
    end else if (wr_en && (wr_addr == rd_addr)) begin
      rd_next = wr_data;
    end
  end

  // Output register; cleared immediately by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data <= '0;
    end else begin
      rd_data <= rd_next;
    end
  end

endmodule

// File: rtl/reg_bank.sv
// 32 x 32-bit MIPS general-purpose register bank: one synchronous write
// port, two registered read ports with write-through bypass, $0 hardwired
// to zero and $29 preloaded with the stack-pointer reset value.
module reg_bank
  import mips_pkg::*;
#(
  parameter int unsigned             DATA_W   = DATA_W_DEF,
  parameter int unsigned             ADDR_W   = ADDR_W_DEF,
  parameter logic [DATA_W-1:0]       SP_RESET = DATA_W'(SP_RESET_DEF)
) (
  input  logic       clk,
  input  logic       reset_n,
  reg_bank_if.slave  bus
);

  localparam int unsigned       NREGS  = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] SP_IDX = ADDR_W'(REG_SP);

  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] array_rd1;
  logic [DATA_W-1:0] array_rd2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;

  // Register array: reset clears everything and preloads $29; writes to $0
  // are dropped so it always holds zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
      regs[SP_IDX] <= SP_RESET;
    end else if (bus.RegWrite && (bus.WriteReg != '0)) begin
      regs[bus.WriteReg] <= bus.WriteData;
    end
  end

  assign array_rd1 = regs[bus.ReadReg1];
  assign array_rd2 = regs[bus.ReadReg2];

  reg_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_port1 (
    .clk        (clk),
    .reset_n    (reset_n),
    .rd_addr    (bus.ReadReg1),
    .wr_en      (bus.RegWrite),
    .wr_addr    (bus.WriteReg),
    .wr_data    (bus.WriteData),
    .array_data (array_rd1),
    .rd_data    (rd_data1)
  );

  reg_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_port2 (
    .clk        (clk),
    .reset_n    (reset_n),
    .rd_addr    (bus.ReadReg2),
    .wr_en      (bus.RegWrite),
    .wr_addr    (bus.WriteReg),
    .wr_data    (bus.WriteData),
    .array_data (array_rd2),
    .rd_data    (rd_data2)
  );

  assign bus.ReadData1 = rd_data1;
  assign bus.ReadData2 = rd_data2;

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank: directed scenarios plus random traffic
// compared against an array-based reference model.
module tb_reg_bank;

  logic clk;
  logic reset_n;

  int unsigned vectors;
  int unsigned miscompares;

  logic [31:0] model [32];

  reg_bank_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  reg_bank #(
    .DATA_W   (32),
    .ADDR_W   (5),
    .SP_RESET (32'd227)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    model[29] = 32'd227;
  endtask

  function automatic logic [31:0] model_read(input logic we, input logic [4:0] wa,
                                              input logic [31:0] wd, input logic [4:0] ra);
    if (ra == 5'd0) return 32'd0;
    if (we && wa == ra) return wd;
    return model[ra];
  endfunction

  // Drive one cycle of stimulus, then check both read ports just after the edge.
  task automatic do_cycle(input string tag, input logic we, input logic [4:0] wa,
                          input logic [31:0] wd, input logic [4:0] r1, input logic [4:0] r2);
    logic [31:0] e1, e2;
    bus.RegWrite  = we;
    bus.WriteReg  = wa;
    bus.WriteData = wd;
    bus.ReadReg1  = r1;
    bus.ReadReg2  = r2;
    e1 = model_read(we, wa, wd, r1);
    e2 = model_read(we, wa, wd, r2);
    @(posedge clk);
    if (we && wa != 5'd0) model[wa] = wd;
    #1;
    check({tag, "_rd1"}, bus.ReadData1, e1);
    check({tag, "_rd2"}, bus.ReadData2, e2);
  endtask

  initial begin
    logic        we;
    logic [4:0]  wa, r1, r2;
    logic [31:0] wd;

    vectors     = 0;
    miscompares = 0;
    reset_n       = 1'b0;
    bus.RegWrite  = 1'b0;
    bus.WriteReg  = '0;
    bus.WriteData = '0;
    bus.ReadReg1  = '0;
    bus.ReadReg2  = '0;
    model_reset();

    // Reset held: outputs zero before and after an edge.
    #3;
    check("rst_hold_rd1", bus.ReadData1, 32'd0);
    check("rst_hold_rd2", bus.ReadData2, 32'd0);
    @(posedge clk); #1;
    check("rst_edge_rd1", bus.ReadData1, 32'd0);
    check("rst_edge_rd2", bus.ReadData2, 32'd0);
    #4 reset_n = 1'b1;

    do_cycle("rst_sp", 1'b0, 5'd0, 32'd0, 5'd29, 5'd5);

    // Basic write then read.
    do_cycle("wr8",   1'b1, 5'd8, 32'hDEADBEEF, 5'd0, 5'd0);
    do_cycle("rd8",   1'b0, 5'd0, 32'd0,        5'd8, 5'd9);

    // $0 protection, including no bypass at the write edge.
    do_cycle("wr0",   1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0);
    do_cycle("rd0",   1'b0, 5'd0, 32'd0,        5'd0, 5'd0);

    // Bypass on $31, first with the write disabled.
    do_cycle("ra_old",   1'b1, 5'd31, 32'h00001111, 5'd0,  5'd0);
    do_cycle("ra_nowr",  1'b0, 5'd31, 32'h00400010, 5'd31, 5'd31);
    do_cycle("ra_byp",   1'b1, 5'd31, 32'h00400010, 5'd31, 5'd31);
    do_cycle("ra_arr",   1'b0, 5'd0,  32'd0,        5'd31, 5'd31);

    // Special destinations on consecutive edges, then read back.
    do_cycle("wr29",  1'b1, 5'd29, 32'hAAAA0001, 5'd0,  5'd0);
    do_cycle("wr30",  1'b1, 5'd30, 32'hAAAA0002, 5'd0,  5'd0);
    do_cycle("wr31",  1'b1, 5'd31, 32'hAAAA0003, 5'd0,  5'd0);
    do_cycle("rd2930", 1'b0, 5'd0, 32'd0,        5'd29, 5'd30);
    do_cycle("rd31",   1'b0, 5'd0, 32'd0,        5'd31, 5'd29);

    // Back-to-back writes to one register: last write wins.
    do_cycle("b2b_a", 1'b1, 5'd12, 32'h0000AAAA, 5'd12, 5'd0);
    do_cycle("b2b_b", 1'b1, 5'd12, 32'h0000BBBB, 5'd12, 5'd12);
    do_cycle("b2b_r", 1'b0, 5'd0,  32'd0,        5'd12, 5'd12);

    // Random traffic, biased toward reading the register being written.
    for (int n = 0; n < 400; n++) begin
      we = ($urandom_range(0, 3) != 0);
      wa = 5'($urandom_range(0, 31));
      wd = $urandom;
      r1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      do_cycle("rand", we, wa, wd, r1, r2);
    end

    // Reset asserted ahead of an edge carrying a write: the write is lost.
    bus.RegWrite  = 1'b1;
    bus.WriteReg  = 5'd3;
    bus.WriteData = 32'h00000055;
    bus.ReadReg1  = 5'd3;
    bus.ReadReg2  = 5'd3;
    #6 reset_n = 1'b0;
    #1;
    check("rst_mid_async_rd1", bus.ReadData1, 32'd0);
    check("rst_mid_async_rd2", bus.ReadData2, 32'd0);
    @(posedge clk); #1;
    model_reset();
    check("rst_mid_edge_rd1", bus.ReadData1, 32'd0);
    check("rst_mid_edge_rd2", bus.ReadData2, 32'd0);
    #4 reset_n = 1'b1;
    do_cycle("rst_mid_rd3", 1'b0, 5'd0, 32'd0, 5'd3, 5'd29);
    do_cycle("rst_mid_rd31", 1'b0, 5'd0, 32'd0, 5'd31, 5'd8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
